video_pattern_gen: RTL and testbench
====================================

// Module: video_pattern_gen
// PURPOSE
//  Parametrised video timing + test-pattern source; the next generation of the colorbar source.
//  Produces HS/VS/DE, 24-bit RGB and pixel coordinates for any CEA/VESA timing set by parameters.
//  Drives dvi_transmitter_top directly in the pclk domain.
//  Pattern is run-time selectable and switches only on frame boundaries.
// PARAMETERS
//  H_SYNC      40    hsync width, pixels
//  H_BP        220   horizontal back porch
//  H_VALID     1280  active pixels per line
//  H_FP        110   horizontal front porch
//  V_SYNC      5     vsync width, lines
//  V_BP        20    vertical back porch
//  V_VALID     720   active lines
//  V_FP        5     vertical front porch
//  HS_POLARITY 1'b1  active level of video_hs
//  VS_POLARITY 1'b0  active level of video_vs
//  GRID_STEP   32    grid pitch in pixels/lines for the grid pattern (>=2)
// PORTS
//  pixel_clk    in   1   pixel clock
//  rst          in   1   async reset, active-high
//  pattern_sel  in   2   0=colorbar 1=gray ramp 2=grid 3=solid
//  solid_rgb    in   24  colour for pattern 3, {R,G,B}
//  video_hs     out  1   horizontal sync
//  video_vs     out  1   vertical sync
//  video_de     out  1   active video
//  video_rgb    out  24  pixel data, 0 when video_de=0
//  pixel_xpos   out  12  active x, 0..H_VALID-1 (0 outside active)
//  pixel_ypos   out  12  active y, 0..V_VALID-1 (0 outside active)
//  frame_start  out  1   one-cycle pulse, first clock of each frame (h_cnt=0,v_cnt=0)
// BEHAVIOUR
//  - H_TOTAL=H_SYNC+H_BP+H_VALID+H_FP, V_TOTAL likewise; 12-bit counters h_cnt/v_cnt.
//  - h_cnt wraps H_TOTAL-1->0; v_cnt increments on that wrap and wraps V_TOTAL-1->0.
//  - Line order: sync, back porch, active, front porch; same for frame.
//  - hs active while h_cnt<H_SYNC; vs active while v_cnt<V_SYNC; inactive level = ~polarity.
//  - de=1 when h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_VALID) and v_cnt in the V equivalent.
//  - All outputs registered; 1 pclk latency from counter state; hs/vs/de/rgb/xpos are cycle-aligned.
//  - Reset: counters 0; hs=~HS_POLARITY, vs=~VS_POLARITY, de=0, rgb=0, xpos=ypos=0, frame_start=0.
//  - First frame_start asserts on the first clock after rst deasserts (counters at 0,0).
//  - pattern_sel sampled into pat_q only when h_cnt=0 && v_cnt=0; never changes mid-frame.
//    pat_q resets to 0 (colorbar). solid_rgb is used live (not latched).
//  - Colorbar: BAR_W=H_VALID/8; bar=min(x/BAR_W,7) via running counter, no divider;
//    last bar absorbs remainder. Order: FFFFFF,FFFF00,00FFFF,00FF00,FF00FF,FF0000,0000FF,000000.
//  - Gray ramp: R=G=B=x[7:0] (wraps every 256 px).
//  - Grid: FFFFFF when x%GRID_STEP==0 or y%GRID_STEP==0, else 000000; modulo by wrap counters.
//  - Reset mid-frame: everything returns to reset values immediately (async), restarts at frame 0.
// CONFIGURATION
//  PATTERN_SCROLL_EN defined: 12-bit frame counter (+1 per frame_start, wraps); colorbar and
//    gray ramp use x'=(x+frame_cnt) mod H_VALID, so the pattern shifts left 1 px per frame.
//    frame_cnt resets to 0. Grid and solid unaffected.
//  Not defined: no frame counter, patterns static; timing outputs identical in both builds.
// TESTING (bench params H 2/3/16/1 -> H_TOTAL=22, V 1/1/4/1 -> V_TOTAL=7, GRID_STEP=4)
//  1 Reset release -> frame_start pulse 1 clk; period 154 clk; hs active 2/22 clk; vs active 22 clk.
//  2 de: high 16 clk per line on 4 lines/frame; xpos 0..15, ypos 0..3; rgb=0 whenever de=0.
//  3 sel=0 -> BAR_W=2: x=0,1 FFFFFF; x=2 FFFF00; x=14,15 000000.
//  4 sel 0->3 mid-frame, solid_rgb=123456 -> remainder of frame colorbar; next frame all 123456.
//  5 sel=2 -> x=0,4,8,12 or y=0 white; (x=1,y=1) 000000; sel=1 -> rgb at x=5 is 050505.
//  6 rst pulse mid-line -> outputs at reset values same cycle; restart gives frame_start; with
//    PATTERN_SCROLL_EN, sel=0 frame 2 x=0 equals frame 0 x=2 (FFFF00).

Source files
------------

// File: rtl/video_pattern_gen.sv
// Video timing generator plus run-time selectable test pattern source.
// Optional build macro PATTERN_SCROLL_EN: colorbar and gray ramp scroll left 1 px per frame.
module video_pattern_gen #(
  parameter int unsigned H_SYNC      = 40,
  parameter int unsigned H_BP        = 220,
  parameter int unsigned H_VALID     = 1280,
  parameter int unsigned H_FP        = 110,
  parameter int unsigned V_SYNC      = 5,
  parameter int unsigned V_BP        = 20,
  parameter int unsigned V_VALID     = 720,
  parameter int unsigned V_FP        = 5,
  parameter logic        HS_POLARITY = 1'b1,
  parameter logic        VS_POLARITY = 1'b0,
  parameter int unsigned GRID_STEP   = 32
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb,
  output logic [11:0] pixel_xpos,
  output logic [11:0] pixel_ypos,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_VALID + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_VALID + V_FP;
  localparam int unsigned H_ACT0  = H_SYNC + H_BP;
  localparam int unsigned H_ACT1  = H_ACT0 + H_VALID;
  localparam int unsigned V_ACT0  = V_SYNC + V_BP;
  localparam int unsigned V_ACT1  = V_ACT0 + V_VALID;
  localparam int unsigned BAR_W   = H_VALID / 8;

  logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        h_wrap, v_last, h_act, v_act, act, frame_first;
  logic [1:0]  pat_q;
  logic [11:0] xr_q, bar_px_q, gx_q, gy_q;
  logic [2:0]  bar_idx_q;
  logic [11:0] line_x0, line_px0;
  logic [2:0]  line_idx0;
  logic [23:0] pat_rgb;

  // Advance a bar position by one pixel; the last bar absorbs the remainder.
  function automatic logic [14:0] bar_step(input logic [2:0] idx, input logic [11:0] px);
    if (idx == 3'd7)                 return {idx, px};
    else if (px == 12'(BAR_W - 1))   return {idx + 3'd1, 12'd0};
    else                             return {idx, px + 12'd1};
  endfunction

  // Colorbar palette, white to black.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Counter next-state and region decode.
  always_comb begin
    h_wrap      = (h_cnt_q == 12'(H_TOTAL - 1));
    v_last      = (v_cnt_q == 12'(V_TOTAL - 1));
    h_cnt_d     = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
    v_cnt_d     = v_cnt_q;
    if (h_wrap) v_cnt_d = v_last ? 12'd0 : v_cnt_q + 12'd1;
    h_act       = (h_cnt_q >= 12'(H_ACT0)) && (h_cnt_q < 12'(H_ACT1));
    v_act       = (v_cnt_q >= 12'(V_ACT0)) && (v_cnt_q < 12'(V_ACT1));
    act         = h_act && v_act;
    frame_first = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
  end

  // Timing counters and frame-boundary pattern latch.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      pat_q   <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      if (frame_first) pat_q <= pattern_sel;
    end
  end

`ifdef PATTERN_SCROLL_EN
  logic [11:0] frame_cnt_q, off_q, spx_q;
  logic [2:0]  sidx_q;

  // Per-frame scroll offset (frame_cnt mod H_VALID) and the bar position it maps to.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      off_q       <= '0;
      spx_q       <= '0;
      sidx_q      <= '0;
    end else if (h_wrap && v_last) begin
      frame_cnt_q <= frame_cnt_q + 12'd1;
      if ((off_q == 12'(H_VALID - 1)) || (frame_cnt_q == 12'hFFF)) begin
        off_q  <= '0;
        spx_q  <= '0;
        sidx_q <= '0;
      end else begin
        off_q           <= off_q + 12'd1;
        {sidx_q, spx_q} <= bar_step(sidx_q, spx_q);
      end
    end
  end

  assign line_x0   = off_q;
  assign line_px0  = spx_q;
  assign line_idx0 = sidx_q;
`else
  assign line_x0   = '0;
  assign line_px0  = '0;
  assign line_idx0 = '0;
`endif

  // Running pixel-position counters replacing divide/modulo.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      xr_q      <= '0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      gx_q      <= '0;
      gy_q      <= '0;
    end else begin
      if (!h_act) begin
        xr_q      <= line_x0;
        bar_px_q  <= line_px0;
        bar_idx_q <= line_idx0;
        gx_q      <= '0;
      end else begin
        if (xr_q == 12'(H_VALID - 1)) begin
          xr_q      <= '0;
          bar_px_q  <= '0;
          bar_idx_q <= '0;
        end else begin
          xr_q                  <= xr_q + 12'd1;
          {bar_idx_q, bar_px_q} <= bar_step(bar_idx_q, bar_px_q);
        end
        gx_q <= (gx_q == 12'(GRID_STEP - 1)) ? 12'd0 : gx_q + 12'd1;
      end
      if (h_wrap) begin
        if (v_act) gy_q <= (gy_q == 12'(GRID_STEP - 1)) ? 12'd0 : gy_q + 12'd1;
        else       gy_q <= '0;
      end
    end
  end

  // Pattern colour for the current pixel.
  always_comb begin
    pat_rgb = 24'h000000;
    case (pat_q)
      2'd0:    pat_rgb = bar_color(bar_idx_q);
      2'd1:    pat_rgb = {3{xr_q[7:0]}};
      2'd2:    pat_rgb = ((gx_q == 12'd0) || (gy_q == 12'd0)) ? 24'hFFFFFF : 24'h000000;
      default: pat_rgb = solid_rgb;
    endcase
  end

  // Registered video outputs, one clock behind the counters.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      video_hs    <= ~HS_POLARITY;
      video_vs    <= ~VS_POLARITY;
      video_de    <= 1'b0;
      video_rgb   <= '0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
      frame_start <= 1'b0;
    end else begin
      video_hs    <= (h_cnt_q < 12'(H_SYNC)) ? HS_POLARITY : ~HS_POLARITY;
      video_vs    <= (v_cnt_q < 12'(V_SYNC)) ? VS_POLARITY : ~VS_POLARITY;
      video_de    <= act;
      video_rgb   <= act ? pat_rgb : 24'h000000;
      pixel_xpos  <= act ? h_cnt_q - 12'(H_ACT0) : 12'd0;
      pixel_ypos  <= act ? v_cnt_q - 12'(V_ACT0) : 12'd0;
      frame_start <= frame_first;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen with a small 22x7 timing set.
module tb_video_pattern_gen;

  localparam int HT = 22;
  localparam int VT = 7;
  localparam int FT = HT * VT;

  logic        pixel_clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_rgb = 24'h0;
  logic        video_hs, video_vs, video_de, frame_start;
  logic [23:0] video_rgb;
  logic [11:0] pixel_xpos, pixel_ypos;

  video_pattern_gen #(
    .H_SYNC(2), .H_BP(3), .H_VALID(16), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_VALID(4), .V_FP(1),
    .HS_POLARITY(1'b1), .VS_POLARITY(1'b0), .GRID_STEP(4)
  ) dut (
    .pixel_clk(pixel_clk), .rst(rst), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de), .video_rgb(video_rgb),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .frame_start(frame_start)
  );

  always #5 pixel_clk = ~pixel_clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          k = 0;
  logic [1:0]  m_pat = 2'd0;
  logic        e_de;
  logic [23:0] e_rgb;
  logic [11:0] e_x, e_y;
  logic [51:0] e_vec;
  int          e_f, e_p;
  logic [51:0] obs;
  localparam logic [51:0] RST_VEC = {1'b0, 1'b1, 1'b0, 24'h0, 12'h0, 12'h0, 1'b0};

  assign obs = {video_hs, video_vs, video_de, video_rgb, pixel_xpos, pixel_ypos, frame_start};

  function automatic logic [23:0] bar_rgb(input int b);
    case (b)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Compute expected outputs for the counter state consumed by the next edge, then clock it.
  task automatic tick();
    int p, f, h, v, x, y, xs, b;
    logic e_hs, e_vs, e_fs;
    p = k % FT;
    f = k / FT;
    if (p == 0) m_pat = pattern_sel;
    h = p % HT;
    v = p / HT;
    e_hs = (h < 2);
    e_vs = (v < 1) ? 1'b0 : 1'b1;
    e_de = (h >= 5) && (h < 21) && (v >= 2) && (v < 6);
    x = e_de ? h - 5 : 0;
    y = e_de ? v - 2 : 0;
    xs = x;
`ifdef PATTERN_SCROLL_EN
    xs = (x + f) % 16;
`endif
    case (m_pat)
      2'd0: begin
        b = xs / 2;
        if (b > 7) b = 7;
        e_rgb = bar_rgb(b);
      end
      2'd1: e_rgb = {3{8'(xs)}};
      2'd2: e_rgb = ((x % 4 == 0) || (y % 4 == 0)) ? 24'hFFFFFF : 24'h000000;
      default: e_rgb = solid_rgb;
    endcase
    if (!e_de) e_rgb = 24'h0;
    e_x = 12'(x);
    e_y = 12'(y);
    e_fs = (p == 0);
    e_f = f;
    e_p = p;
    e_vec = {e_hs, e_vs, e_de, e_rgb, e_x, e_y, e_fs};
    @(posedge pixel_clk);
    k++;
    @(negedge pixel_clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pattern_sel = 2'd0;
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    n_checks++;
    if (obs !== RST_VEC) $display("FAIL reset_vec got=%h exp=%h", obs, RST_VEC); else n_pass++;
    n_checks++;
    if (video_hs !== 1'b0) $display("FAIL reset_hs got=%b exp=0", video_hs); else n_pass++;
    n_checks++;
    if (video_vs !== 1'b1) $display("FAIL reset_vs got=%b exp=1", video_vs); else n_pass++;
    rst = 1'b0;
    k = 0;
    m_pat = 2'd0;
  endtask

  task automatic test_timing_colorbar_switch();
    int hs_cnt, vs_cnt, de_cnt;
    int fs_k[$];
    hs_cnt = 0; vs_cnt = 0; de_cnt = 0;
    pattern_sel = 2'd0;
    solid_rgb = 24'h123456;
    for (int i = 0; i < 2 * FT; i++) begin
      if (i == 80) pattern_sel = 2'd3;
      tick();
      n_checks++;
      if (obs !== e_vec) $display("FAIL frame_model k=%0d got=%h exp=%h", k, obs, e_vec); else n_pass++;
      if (e_f == 0 && e_p < HT && video_hs === 1'b1) hs_cnt++;
      if (e_f == 0 && video_vs === 1'b0) vs_cnt++;
      if (e_f == 0 && video_de === 1'b1) de_cnt++;
      if (frame_start === 1'b1) fs_k.push_back(k);
      if (video_de !== 1'b1) begin
        n_checks++;
        if (video_rgb !== 24'h0) $display("FAIL rgb_blank k=%0d got=%h exp=000000", k, video_rgb); else n_pass++;
      end
      if (e_f == 0 && e_de && e_y == 12'd0 && (e_x <= 12'd2 || e_x >= 12'd14)) begin
        n_checks++;
        if (video_rgb !== (e_x <= 12'd1 ? 24'hFFFFFF : (e_x == 12'd2 ? 24'hFFFF00 : 24'h000000)))
          $display("FAIL colorbar x=%0d got=%h", e_x, video_rgb);
        else n_pass++;
      end
      if (e_f == 1 && e_de) begin
        n_checks++;
        if (video_rgb !== 24'h123456) $display("FAIL solid_next_frame k=%0d got=%h exp=123456", k, video_rgb); else n_pass++;
      end
    end
    n_checks++;
    if (hs_cnt != 2) $display("FAIL hs_width got=%0d exp=2", hs_cnt); else n_pass++;
    n_checks++;
    if (vs_cnt != HT) $display("FAIL vs_width got=%0d exp=%0d", vs_cnt, HT); else n_pass++;
    n_checks++;
    if (de_cnt != 64) $display("FAIL de_per_frame got=%0d exp=64", de_cnt); else n_pass++;
    n_checks++;
    if (fs_k.size() != 2) $display("FAIL frame_start_count got=%0d exp=2", fs_k.size());
    else if (fs_k[0] != 1 || fs_k[1] != 1 + FT) $display("FAIL frame_start_period got=%0d,%0d exp=1,%0d", fs_k[0], fs_k[1], 1 + FT);
    else n_pass++;
  endtask

  task automatic test_grid_gray();
    int n;
    pattern_sel = 2'd2;
    n = (FT - (k % FT)) % FT + FT;
    for (int i = 0; i < n; i++) begin
      tick();
      n_checks++;
      if (obs !== e_vec) $display("FAIL grid_model k=%0d got=%h exp=%h", k, obs, e_vec); else n_pass++;
      if (m_pat == 2'd2 && e_de) begin
        n_checks++;
        if (video_rgb !== ((e_x % 4 == 0 || e_y == 12'd0) ? 24'hFFFFFF : 24'h000000))
          $display("FAIL grid x=%0d y=%0d got=%h", e_x, e_y, video_rgb);
        else n_pass++;
      end
    end
    pattern_sel = 2'd1;
    n = (FT - (k % FT)) % FT + FT;
    for (int i = 0; i < n; i++) begin
      tick();
      n_checks++;
      if (obs !== e_vec) $display("FAIL gray_model k=%0d got=%h exp=%h", k, obs, e_vec); else n_pass++;
`ifndef PATTERN_SCROLL_EN
      if (m_pat == 2'd1 && e_de && e_x == 12'd5) begin
        n_checks++;
        if (video_rgb !== 24'h050505) $display("FAIL gray_x5 got=%h exp=050505", video_rgb); else n_pass++;
      end
`endif
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3 * FT; i++) begin
      if ($urandom_range(0, 39) == 0) pattern_sel = 2'($urandom);
      solid_rgb = 24'($urandom);
      tick();
      n_checks++;
      if (obs !== e_vec) $display("FAIL random_model k=%0d got=%h exp=%h", k, obs, e_vec); else n_pass++;
    end
  endtask

  task automatic test_reset_midline();
    pattern_sel = 2'd0;
    repeat (40 + $urandom_range(0, 10)) tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== RST_VEC) $display("FAIL async_reset got=%h exp=%h", obs, RST_VEC); else n_pass++;
    k = 0;
    m_pat = 2'd0;
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    n_checks++;
    if (obs !== RST_VEC) $display("FAIL reset_hold got=%h exp=%h", obs, RST_VEC); else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 3 * FT; i++) begin
      tick();
      n_checks++;
      if (obs !== e_vec) $display("FAIL restart_model k=%0d got=%h exp=%h", k, obs, e_vec); else n_pass++;
      if (i == 0) begin
        n_checks++;
        if (frame_start !== 1'b1) $display("FAIL restart_frame_start got=%b exp=1", frame_start); else n_pass++;
      end
      if (e_f == 2 && e_de && e_x == 12'd0 && e_y == 12'd0) begin
        n_checks++;
`ifdef PATTERN_SCROLL_EN
        if (video_rgb !== 24'hFFFF00) $display("FAIL scroll_frame2 got=%h exp=FFFF00", video_rgb); else n_pass++;
`else
        if (video_rgb !== 24'hFFFFFF) $display("FAIL static_frame2 got=%h exp=FFFFFF", video_rgb); else n_pass++;
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing_colorbar_switch();
    test_grid_gray();
    test_random();
    test_reset_midline();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
